quarterwav_dds: RTL

//  Parametrised successor to the quarter-wave sine table: a phase-accumulator sine generator (DDS).

---
 rtl/quarterwav_dds.sv | 133 +++++++++++++
 1 files changed

// File: rtl/quarterwav_dds.sv
// Phase-accumulator sine generator built on a (2^LGTBL+1)-entry quarter-wave table.
// Define QWAVE_COS_EN to add the quadrature (cosine) output and its second table read.
module quarterwav_dds #(
  parameter int PW    = 32,
  parameter int LGTBL = 8,
  parameter int OW    = 12
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic                 i_load,
  input  logic [PW-1:0]        i_step,
  input  logic [PW-1:0]        i_offset,
  input  logic                 i_sync,
  input  logic                 i_aux,
  output logic signed [OW-1:0] o_val,
`ifdef QWAVE_COS_EN
  output logic signed [OW-1:0] o_cos,
`endif
  output logic                 o_valid,
  output logic                 o_aux
);

  localparam int          DEPTH   = (1 << LGTBL) + 1;
  localparam longint      PI_Q30  = 64'sd3373259426;
  localparam logic [LGTBL:0] FULL = {1'b1, {LGTBL{1'b0}}};

  // Table entry k = round((2^(OW-1)-1) * sin(k*pi/2^(LGTBL+1))), Q30 Taylor series at elaboration.
  function automatic logic [OW-2:0] rom_val(input int k);
    longint x, t, s, y;
    x = (longint'(k) * PI_Q30) >>> (LGTBL + 1);
    t = x;
    s = x;
    for (int n = 1; n < 8; n++) begin
      t = -((((t * x) >>> 30) * x) >>> 30) / longint'((2 * n) * (2 * n + 1));
      s = s + t;
    end
    y = (s * longint'((1 << (OW - 1)) - 1) + (64'sd1 <<< 29)) >>> 30;
    return y[OW-2:0];
  endfunction

  function automatic logic [LGTBL:0] fold(input logic odd, input logic [LGTBL-1:0] f);
    return odd ? FULL - {1'b0, f} : {1'b0, f};
  endfunction

  logic [OW-2:0] w_rom [0:DEPTH-1];
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign w_rom[k] = rom_val(k);
  end

  logic [PW-1:0]    r_step, r_acc;
  logic [LGTBL:0]   r_addr;
  logic             r_neg, r_neg2;
  logic [OW-2:0]    r_mag;
  logic [2:0]       r_aux;
  logic [1:0]       r_fill;

  logic [PW-1:0]    w_p;
  logic [1:0]       w_q;
  logic [LGTBL-1:0] w_f;
  logic [LGTBL:0]   w_addr;
  logic signed [OW-1:0] w_mag;

  assign w_p    = r_acc + i_offset;
  assign w_q    = w_p[PW-1:PW-2];
  assign w_f    = w_p[PW-3 -: LGTBL];
  assign w_addr = fold(w_q[0], w_f);
  assign w_mag  = {1'b0, r_mag};

  if (PW > LGTBL + 2) begin : g_lsb
    logic w_unused_lsb;
    assign w_unused_lsb = ^w_p[PW-LGTBL-3:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_step <= '0;
      r_acc  <= '0;
      r_addr <= '0;
      r_neg  <= 1'b0;
      r_mag  <= '0;
      r_neg2 <= 1'b0;
      o_val  <= '0;
      r_aux  <= '0;
      o_aux  <= 1'b0;
      r_fill <= '0;
    end else begin
      if (i_load) r_step <= i_step;
      if (i_ce) begin
        // stage 1 sees the pre-update accumulator, so a load with i_ce uses the old step
        r_acc  <= i_sync ? '0 : r_acc + r_step;
        r_addr <= w_addr;
        r_neg  <= w_q[1];
        r_mag  <= w_rom[r_addr];
        r_neg2 <= r_neg;
        o_val  <= r_neg2 ? -w_mag : w_mag;
        r_aux  <= {r_aux[1:0], i_aux};
        o_aux  <= r_aux[2];
        if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
      end
    end
  end

  assign o_valid = (r_fill == 2'd3);

`ifdef QWAVE_COS_EN
  logic [1:0]     w_qc;
  logic [LGTBL:0] r_addr_c;
  logic           r_neg_c, r_neg2_c;
  logic [OW-2:0]  r_mag_c;
  logic signed [OW-1:0] w_mag_c;

  assign w_qc    = w_q + 2'd1;
  assign w_mag_c = {1'b0, r_mag_c};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr_c <= '0;
      r_neg_c  <= 1'b0;
      r_mag_c  <= '0;
      r_neg2_c <= 1'b0;
      o_cos    <= '0;
    end else if (i_ce) begin
      r_addr_c <= fold(w_qc[0], w_f);
      r_neg_c  <= w_qc[1];
      r_mag_c  <= w_rom[r_addr_c];
      r_neg2_c <= r_neg_c;
      o_cos    <= r_neg2_c ? -w_mag_c : w_mag_c;
    end
  end
`endif

endmodule
